// File: rtl/wordcell_pkg.sv
// Shared types and constants for the Wordcell latch-bank controller.
package wordcell_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  localparam logic OP_WRITE   = 1'b1;
  localparam logic OP_READ    = 1'b0;
  localparam int   DEF_WORDS  = 8;
  localparam int   DEF_DATA_W = 8;
  // Strobe down-counter width; covers STROBE_CYC up to 15.
  localparam int   CNT_W      = 4;
endpackage

// File: rtl/wordcell_mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       upd_en,
  output logic [1:0] grant
);
  logic last_grant;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   last_grant <= 1'b1;
    else if (upd_en && |grant)    last_grant <= grant[1];
  end
endmodule

// File: rtl/wordcell_mem_ctrl.sv
// Sequences arbitrated requests into setup / select-strobe / hold accesses of a latch bank.
module wordcell_mem_ctrl
  import wordcell_pkg::*;
#(
  parameter int WORDS      = DEF_WORDS,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STROBE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_we,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_wdata,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_wdata,
  output logic                    rsp0_valid,
  output logic                    rsp1_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_op,
  output logic [WORDS-1:0]        mem_sel,
  output logic [DATA_W-1:0]       mem_in_bus,
  input  logic [WORDS*DATA_W-1:0] mem_out_flat,
  output logic                    busy
);
  typedef struct packed {
    logic              we;
    logic              own;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q, req_in;
  logic [CNT_W-1:0] cnt;
  logic             err_q, accept, in_range, drive;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic [1:0]       req_valid, grant;

  assign req_valid = {req1_valid, req0_valid};
  assign accept    = rst_n && (state == IDLE) && |req_valid;
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];
  assign req_in = grant[1] ? {req1_we, 1'b1, req1_addr, req1_wdata}
                           : {req0_we, 1'b0, req0_addr, req0_wdata};
  // Extra bit so WORDS == 2**ADDR_W does not wrap to zero.
  assign in_range = {1'b0, req_q.addr} < (ADDR_W+1)'(WORDS);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .upd_en (accept),
    .grant  (grant)
  );

  always_comb begin
    rd_word = '0;
    mem_sel = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (req_q.addr == ADDR_W'(k)) rd_word = mem_out_flat[k*DATA_W +: DATA_W];
      mem_sel[k] = (state == STROBE) && (req_q.addr == ADDR_W'(k));
    end
  end

  always_comb begin
    state_nxt  = state;
    drive      = (state == SETUP) || (state == STROBE) || (state == HOLD);
    mem_op     = OP_READ;
    mem_in_bus = '0;
    busy       = (state != IDLE);
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    // op and bus are held across SETUP..HOLD so they never move while a select is high
    if (drive) begin
      mem_op = req_q.we;
      if (req_q.we == OP_WRITE) mem_in_bus = req_q.wdata;
    end
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    state_nxt = RESP;
      RESP: begin
        state_nxt  = IDLE;
        rsp0_valid = !req_q.own;
        rsp1_valid = req_q.own;
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          req_q   <= req_in;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        SETUP: cnt <= CNT_W'(STROBE_CYC - 1);
        STROBE: begin
          err_q <= !in_range;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (req_q.we == OP_READ && in_range) rdata_q <= rd_word;
        end
        default: ;
      endcase
    end
  end
endmodule
